// File: rtl/fpu_mul_norm_round.sv
// Normalize, round and pack stage for the binary32 multiply path.
// Stage 1 normalizes the truncated product and adds exponents; stage 2 rounds
// (nearest, ties away), range-checks and packs, with special-case override.
module fpu_mul_norm_round #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 24,
   parameter int unsigned BIAS  = 127
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [MAN_W-1:0]         mul_result,
   input  logic                     mul_redundant,
   input  logic                     sign_x,
   input  logic                     sign_y,
   input  logic [EXP_W-1:0]         exp_x,
   input  logic [EXP_W-1:0]         exp_y,
   input  logic                     frac_nz_x,
   input  logic                     frac_nz_y,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W-1:0]   out_result,
   output logic                     flag_overflow,
   output logic                     flag_underflow,
   output logic                     flag_invalid,
   output logic                     flag_inexact
);

   // Two extra bits give a signed exponent wide enough for 2*max - bias + 1.
   localparam int unsigned EW = EXP_W + 2;
   localparam int unsigned RW = EXP_W + MAN_W;
   localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

   typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} cls_e;

   logic             stall;
   logic             zero_x, zero_y, inf_x, inf_y, nan_x, nan_y;
   cls_e             cls_d;
   logic [EW-1:0]    exp_d;
   logic [MAN_W-1:0] man_d;
   logic             guard_d;

   logic             s1_valid;
   logic             s1_sign;
   logic [EW-1:0]    s1_exp;
   logic [MAN_W-1:0] s1_man;
   logic             s1_guard;
   cls_e             s1_cls;

   logic [MAN_W:0]   man_r;
   logic [EW-1:0]    exp_r;
   logic [RW-1:0]    res_d;
   logic             ovf_d, unf_d, inv_d, inx_d;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   assign zero_x = (exp_x == '0);
   assign zero_y = (exp_y == '0);
   assign inf_x  = (exp_x == '1) && !frac_nz_x;
   assign inf_y  = (exp_y == '1) && !frac_nz_y;
   assign nan_x  = (exp_x == '1) && frac_nz_x;
   assign nan_y  = (exp_y == '1) && frac_nz_y;

   // Stage 1 combinational: classify operands, normalize product, add exponents.
   always_comb begin
      cls_d = ClsNorm;
      if (nan_x || nan_y || (inf_x && zero_y) || (inf_y && zero_x)) begin
         cls_d = ClsNan;
      end else if (inf_x || inf_y) begin
         cls_d = ClsInf;
      end else if (zero_x || zero_y) begin
         cls_d = ClsZero;
      end
      exp_d   = EW'(exp_x) + EW'(exp_y) - EW'(BIAS) + EW'(mul_redundant);
      man_d   = mul_redundant ? {1'b1, mul_result[MAN_W-1:1]} : mul_result;
      guard_d = mul_redundant & mul_result[0];
   end

   // Stage 1 register: advances whenever the output is not stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_exp   <= '0;
         s1_man   <= '0;
         s1_guard <= 1'b0;
         s1_cls   <= ClsNorm;
      end else if (!stall) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign  <= sign_x ^ sign_y;
            s1_exp   <= exp_d;
            s1_man   <= man_d;
            s1_guard <= guard_d;
            s1_cls   <= cls_d;
         end
      end
   end

   // Stage 2 combinational: round, range check, pack, special-case override.
   always_comb begin
      res_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inv_d = 1'b0;
      inx_d = 1'b0;
      man_r = {1'b0, s1_man} + (MAN_W+1)'(s1_guard);
      exp_r = s1_exp + EW'(man_r[MAN_W]);
      // A carry out leaves 1.000..., so the fraction field is already zero.
      if (man_r[MAN_W]) begin
         man_r[MAN_W-1:0] = {1'b1, {(MAN_W-1){1'b0}}};
      end
      unique case (s1_cls)
         ClsNan: begin
            res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-2){1'b0}}};
            inv_d = 1'b1;
         end
         ClsInf:  res_d = {s1_sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
         ClsZero: res_d = {s1_sign, {(RW-1){1'b0}}};
         ClsNorm: begin
            inx_d = s1_guard;
            if (!exp_r[EW-1] && (exp_r >= EXP_MAX)) begin
               res_d = {s1_sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
               ovf_d = 1'b1;
               inx_d = 1'b1;
            end else if (exp_r[EW-1] || (exp_r == '0)) begin
               res_d = {s1_sign, {(RW-1){1'b0}}};
               unf_d = 1'b1;
               inx_d = (s1_man != '0);
            end else begin
               res_d = {s1_sign, exp_r[EXP_W-1:0], man_r[MAN_W-2:0]};
            end
         end
      endcase
   end

   // Stage 2 register: result and flags only change when a valid S1 entry moves in.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_result     <= '0;
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
         flag_invalid   <= 1'b0;
         flag_inexact   <= 1'b0;
      end else if (!stall) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_result     <= res_d;
            flag_overflow  <= ovf_d;
            flag_underflow <= unf_d;
            flag_invalid   <= inv_d;
            flag_inexact   <= inx_d;
         end
      end
   end

endmodule

// File: doc/fpu_mul_norm_round.md
# fpu_mul_norm_round

Two-stage pipelined normalize/round/pack stage for the single-precision FP multiply path. It sits directly downstream of the 24x24 mantissa multiplier. It consumes the multiplier's truncated upper product (`mul_result`) and overflow-position bit (`mul_redundant`), together with the operand signs, exponents and class hints. It produces a packed IEEE-754 binary32 result plus exception flags, using a valid/ready handshake toward the FPU writeback.

## Interface
Parameters:
- `EXP_W`, default 8: exponent width.
- `MAN_W`, default 24: mantissa width, hidden bit included.
- `BIAS`, default 127: exponent bias.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `in_valid`: input, 1 bit. Upstream transaction valid.
- `in_ready`: output, 1 bit. Stage can accept a transaction.
- `mul_result`: input, `MAN_W` bits. Product bits [46:23] from the mantissa multiplier.
- `mul_redundant`: input, 1 bit. Product bit 47.
- `sign_x`, `sign_y`: input, 1 bit each. Operand signs.
- `exp_x`, `exp_y`: input, `EXP_W` bits each. Biased operand exponents.
- `frac_nz_x`, `frac_nz_y`: input, 1 bit each. Operand fraction field is nonzero.
- `out_valid`: output, 1 bit. Result valid.
- `out_ready`: input, 1 bit. Downstream accepts the result.
- `out_result`: output, 32 bits. Packed binary32 result.
- `flag_overflow`, `flag_underflow`, `flag_invalid`, `flag_inexact`: output, 1 bit each. Exception flags, qualified by `out_valid`.

## Operation
Operand classification is done from the exponent and fraction hint:
- exp = 0 means zero. Denormal inputs are flushed to zero.
- exp = all-ones with `frac_nz` = 0 means inf.
- exp = all-ones with `frac_nz` = 1 means NaN.

Stage 1 (S1): normalize and add exponents.
- `sign` = `sign_x` ^ `sign_y`.
- Exponent arithmetic uses a 10-bit signed intermediate: `e` = `exp_x` + `exp_y` − `BIAS` + `mul_redundant`.
- If `mul_redundant` = 1: mantissa `m` = {1, `mul_result[23:1]`}, guard `g` = `mul_result[0]`.
- If `mul_redundant` = 0: `m` = `mul_result`, `g` = 0. The product bit below is not available.
- S1 registers `sign`, `e`, `m`, `g` and a 2-bit class code: normal, zero, inf, NaN.

Stage 2 (S2): round, range check, pack.
- Rounding is round-to-nearest, ties away from zero; no sticky bit is available. `m_r` = `m` + `g`, computed 25 bits wide.
- If `m_r` carries out (bit 24 set), then `m_r` becomes 0x800000 and `e` becomes `e` + 1.
- `flag_inexact` = `g`, for normal results only.
- If `e` ≥ 255: result is {sign, 0xFF, 0}, i.e. signed inf. Set `flag_overflow` and `flag_inexact`.
- If `e` ≤ 0: result is signed zero {sign, 31'b0}, flushed. Set `flag_underflow`, and set `flag_inexact` if `m` ≠ 0.
- Otherwise: result is {sign, `e[7:0]`, `m_r[22:0]`}.

Special cases override the arithmetic path, in priority order:
1. Either operand NaN, or inf × zero → 0x7FC00000. `flag_invalid` = 1 in the inf × zero case and for any NaN operand. No other flags.
2. Either operand inf → signed inf, no flags.
3. Either operand zero → signed zero, no flags.

## Timing
Latency and throughput:
- Latency is exactly 2 cycles from an accepted input (`in_valid` && `in_ready` at edge N) to `out_valid` at edge N+2, assuming no stall.
- Throughput is 1 transaction per cycle.

Stall and flow control:
- `stall` = `out_valid` && !`out_ready`.
- `in_ready` = !`stall`. It is combinational from `out_ready` and the S2 valid register.
- While stalled, the S1 and S2 registers, `out_result` and the flags hold their values unchanged.
- A bubble in S1 (no S1 valid) does not block S2.

Simultaneous events:
- Input accepted in the same cycle an output is consumed: both happen, and the pipeline shifts.
- `in_valid` = 0 while not stalled: a bubble is inserted and S1 valid clears.

Reset (synchronous):
- Applies at any time, including mid-operation and during a stall.
- Next cycle: `out_valid` = 0, S1 valid = 0, `out_result` = 0, all flags = 0.
- `in_ready` = 1 the cycle after reset deasserts.
- In-flight transactions are discarded.

Output constraint: `out_result` and the flags change only on a cycle where S2 loads.

## Test plan
- 1.5 × 1.5: `exp_x` = `exp_y` = 0x7F, `mul_redundant` = 1, `mul_result` = 0x200000, signs 0 → after 2 cycles `out_result` = 0x40100000 (2.25), no flags.
- 1.0 × 1.0: exponents 0x7F, `mul_redundant` = 0, `mul_result` = 0x800000 → 0x3F800000, no flags.
- Rounding carry: `sign_x` = 1, exponents 0x7F, `mul_redundant` = 1, `mul_result` = 0xFFFFFF → 0xC0800000, `flag_inexact` = 1.
- Overflow: exponents 0xFE, `mul_redundant` = 0, `mul_result` = 0x800000 → 0x7F800000, `flag_overflow` = 1 and `flag_inexact` = 1. Underflow: exponents 0x01 → 0x00000000, `flag_underflow` = 1.
- Specials: inf × zero (`exp_x` = 0xFF, `frac_nz_x` = 0, `exp_y` = 0) → 0x7FC00000, `flag_invalid` = 1. inf × 2.0 with `sign_y` = 1 → 0xFF800000, no flags.
- Backpressure and reset:
  - Send 3 back-to-back transactions with `out_ready` = 0 for 3 cycles → first result holds stable, `in_ready` = 0, no loss or duplication. Release → results emerge in order on consecutive cycles.
  - Assert `rst` mid-stall → `out_valid` = 0 next cycle, all outputs 0.
